scan_delay_sequencer: RTL and testbench

- Executor-side initiator for the scan clock timer handshake.
- Accepts delay commands decoded from the vector file and validates the delay byte.
- Drives the timer's start/delay inputs, waits for its done pulse, and generates the single-cycle go_step_tck in TCK step mode.
- Reports completion, abort and error to the executor main FSM.

---
 rtl/scan_delay_sequencer_pkg.sv | 39 +++
 rtl/step_edge_sync.sv | 34 +++
 rtl/scan_delay_sequencer.sv | 176 +++++++++++++++++
 tb/tb_scan_delay_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_delay_sequencer_pkg.sv
// Shared definitions for the scan delay sequencer and the scan clock timer.
// Holds the sequencer state encoding, error codes and the delay byte layout
// (multiplier in [7:4], exponent in [3:0]) together with the largest exponent
// the timer honours.
package scan_delay_sequencer_pkg;

    localparam int unsigned SEQ_STATE_W = 3;
    localparam int unsigned ERR_CODE_W  = 2;
    localparam int unsigned DELAY_W     = 8;
    localparam int unsigned DLY_MULT_W  = 4;
    localparam int unsigned DLY_EXP_W   = 4;
    localparam int unsigned MAX_EXP     = 7;

    typedef enum logic [SEQ_STATE_W-1:0] {
        SEQ_IDLE      = 3'd0,
        SEQ_ISSUE     = 3'd1,
        SEQ_WAIT_DONE = 3'd2,
        SEQ_COMPLETE  = 3'd3,
        SEQ_ABORT     = 3'd4,
        SEQ_ERROR     = 3'd5
    } seq_state_e;

    localparam logic [ERR_CODE_W-1:0] ERR_NONE      = 2'b00;
    localparam logic [ERR_CODE_W-1:0] ERR_BAD_EXP   = 2'b01;
    localparam logic [ERR_CODE_W-1:0] ERR_TIMEOUT   = 2'b10;
    localparam logic [ERR_CODE_W-1:0] ERR_DONE_IDLE = 2'b11;

    // Delay byte as decoded from the vector file: value = mult * 10^exp cycles.
    typedef struct packed {
        logic [DLY_MULT_W-1:0] mult;
        logic [DLY_EXP_W-1:0]  exp;
    } delay_t;

    // Exponents above MAX_EXP would be silently clamped by the timer.
    function automatic logic exp_legal(input logic [DLY_EXP_W-1:0] e);
        return e <= DLY_EXP_W'(MAX_EXP);
    endfunction

endpackage

// File: rtl/step_edge_sync.sv
// Operator button conditioner: SYNC_STAGES-deep synchronizer followed by a
// rising-edge detector. edge_pulse_c is high for one clk cycle per press.
// Ports:
//   clk, reset (sync, active high)
//   button        raw asynchronous button level
//   edge_pulse_c  one-cycle pulse on each synchronized rising edge (comb)
module step_edge_sync
    import scan_delay_sequencer_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic edge_pulse_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    // Metastability chain plus one history bit for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], button};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_pulse_c = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/scan_delay_sequencer.sv
// Executor-side initiator for the scan clock timer handshake. Validates delay
// commands, starts the timer, waits for its done pulse (with optional
// watchdog), releases TCK steps from the operator button and reports
// completion / abort / error back to the executor.
// Optional feature: define SCAN_DELAY_SEQ_WATCHDOG_EN to build the WAIT_DONE
// watchdog (timeout after WDOG_LIMIT counted cycles, error code 10).
// Ports:
//   clk, reset (sync, active high)
//   cmd_valid/cmd_delay/cmd_ready   command handshake, delay byte {mult,exp}
//   abort                           cancel a pending delay
//   step_mode_tck, step_button      TCK step mode and raw step request
//   timer_start/timer_delay/timer_reset/timer_done/go_step_tck  timer side
//   seq_done, seq_err, seq_err_code, seq_state                  status
module scan_delay_sequencer
    import scan_delay_sequencer_pkg::*;
#(
    parameter logic [31:0] WDOG_LIMIT  = 32'd1_600_000_000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    input  logic [DELAY_W-1:0]     cmd_delay,
    output logic                   cmd_ready,
    input  logic                   abort,
    input  logic                   step_mode_tck,
    input  logic                   step_button,
    output logic                   timer_start,
    output logic [DELAY_W-1:0]     timer_delay,
    output logic                   timer_reset,
    input  logic                   timer_done,
    output logic                   go_step_tck,
    output logic                   seq_done,
    output logic                   seq_err,
    output logic [ERR_CODE_W-1:0]  seq_err_code,
    output logic [SEQ_STATE_W-1:0] seq_state
);

    seq_state_e state_q;
    delay_t     cmd;
    logic       step_edge_c;
    logic       wdog_expired_c;

    assign cmd       = delay_t'(cmd_delay);
    assign seq_state = SEQ_STATE_W'(state_q);

    step_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_step_sync (
        .clk          (clk),
        .reset        (reset),
        .button       (step_button),
        .edge_pulse_c (step_edge_c)
    );

`ifdef SCAN_DELAY_SEQ_WATCHDOG_EN
    logic [31:0] wdog_q;
    // Expiry only counts while the counter is actually running.
    assign wdog_expired_c = !step_mode_tck && (wdog_q == WDOG_LIMIT - 32'd1);
`else
    logic unused_wdog_limit;
    assign unused_wdog_limit = ^WDOG_LIMIT;
    assign wdog_expired_c    = 1'b0;
`endif

    // Sequencer FSM; every output is registered and pulses default low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SEQ_IDLE;
            cmd_ready    <= 1'b0;
            timer_start  <= 1'b0;
            timer_delay  <= '0;
            timer_reset  <= 1'b0;
            go_step_tck  <= 1'b0;
            seq_done     <= 1'b0;
            seq_err      <= 1'b0;
            seq_err_code <= ERR_NONE;
`ifdef SCAN_DELAY_SEQ_WATCHDOG_EN
            wdog_q       <= '0;
`endif
        end else begin
            cmd_ready   <= 1'b0;
            timer_start <= 1'b0;
            timer_reset <= 1'b0;
            go_step_tck <= 1'b0;
            seq_done    <= 1'b0;

            case (state_q)
                SEQ_IDLE: begin
                    if (timer_done) begin
                        state_q      <= SEQ_ERROR;
                        seq_err      <= 1'b1;
                        seq_err_code <= ERR_DONE_IDLE;
                    end else if (cmd_valid && cmd_ready) begin
                        if (cmd.mult == '0) begin
                            // Zero delay: complete without touching the timer.
                            state_q  <= SEQ_COMPLETE;
                            seq_done <= 1'b1;
                        end else if (!exp_legal(cmd.exp)) begin
                            state_q      <= SEQ_ERROR;
                            seq_err      <= 1'b1;
                            seq_err_code <= ERR_BAD_EXP;
                        end else begin
                            state_q     <= SEQ_ISSUE;
                            timer_delay <= cmd_delay;
                            timer_start <= 1'b1;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end

                SEQ_ISSUE: begin
`ifdef SCAN_DELAY_SEQ_WATCHDOG_EN
                    wdog_q <= '0;
`endif
                    if (abort) begin
                        state_q     <= SEQ_ABORT;
                        timer_reset <= 1'b1;
                    end else begin
                        state_q <= SEQ_WAIT_DONE;
                    end
                end

                SEQ_WAIT_DONE: begin
                    // abort outranks a simultaneous done.
                    if (abort) begin
                        state_q     <= SEQ_ABORT;
                        timer_reset <= 1'b1;
                    end else if (timer_done) begin
                        state_q  <= SEQ_COMPLETE;
                        seq_done <= 1'b1;
                    end else if (wdog_expired_c) begin
                        state_q      <= SEQ_ERROR;
                        timer_reset  <= 1'b1;
                        seq_err      <= 1'b1;
                        seq_err_code <= ERR_TIMEOUT;
                    end else begin
                        go_step_tck <= step_edge_c && step_mode_tck;
`ifdef SCAN_DELAY_SEQ_WATCHDOG_EN
                        // Held while the operator is single-stepping.
                        if (!step_mode_tck) begin
                            wdog_q <= wdog_q + 32'd1;
                        end
`endif
                    end
                end

                SEQ_COMPLETE: begin
                    if (timer_done) begin
                        state_q      <= SEQ_ERROR;
                        seq_err      <= 1'b1;
                        seq_err_code <= ERR_DONE_IDLE;
                    end else begin
                        state_q   <= SEQ_IDLE;
                        cmd_ready <= 1'b1;
                    end
                end

                SEQ_ABORT: begin
                    state_q   <= SEQ_IDLE;
                    cmd_ready <= 1'b1;
                end

                SEQ_ERROR: begin
                    state_q <= SEQ_ERROR;
                end

                default: begin
                    state_q <= SEQ_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_delay_sequencer.sv
// Scoreboard bench for scan_delay_sequencer. Stimulus derives the expected
// output events (kind, data, cycle) from the command rules and queues them;
// a monitor pops and compares each event the DUT produces.
module tb_scan_delay_sequencer;

    localparam int unsigned SYNC = 2;
    localparam logic [31:0] WDOG = 32'd100;

    localparam int K_START = 0;
    localparam int K_GO    = 1;
    localparam int K_DONE  = 2;
    localparam int K_RST   = 3;
    localparam int K_ERR   = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_delay = 8'h00;
    logic       abort = 1'b0;
    logic       step_mode_tck = 1'b0;
    logic       step_button = 1'b0;
    logic       timer_done = 1'b0;
    logic       cmd_ready;
    logic       timer_start;
    logic [7:0] timer_delay;
    logic       timer_reset;
    logic       go_step_tck;
    logic       seq_done;
    logic       seq_err;
    logic [1:0] seq_err_code;
    logic [2:0] seq_state;

    always #5 clk = ~clk;

    scan_delay_sequencer #(
        .WDOG_LIMIT  (WDOG),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_delay     (cmd_delay),
        .cmd_ready     (cmd_ready),
        .abort         (abort),
        .step_mode_tck (step_mode_tck),
        .step_button   (step_button),
        .timer_start   (timer_start),
        .timer_delay   (timer_delay),
        .timer_reset   (timer_reset),
        .timer_done    (timer_done),
        .go_step_tck   (go_step_tck),
        .seq_done      (seq_done),
        .seq_err       (seq_err),
        .seq_err_code  (seq_err_code),
        .seq_state     (seq_state)
    );

    // Cycle index: number of rising edges so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc_at;
    } ev_t;
    ev_t exp_q[$];

    function automatic string kname(input int k);
        case (k)
            K_START: return "timer_start";
            K_GO:    return "go_step_tck";
            K_DONE:  return "seq_done";
            K_RST:   return "timer_reset";
            K_ERR:   return "seq_err";
            default: return "?";
        endcase
    endfunction

    task automatic expect_ev(input int k, input logic [7:0] d, input int at);
        exp_q.push_back(ev_t'{kind: k, data: d, cyc_at: at});
    endtask

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic got(input int k, input logic [7:0] d);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_%s: got data=%0h at cycle %0d, want no event", kname(k), d, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.data != d || e.cyc_at != cyc) begin
                failures++;
                $display("FAIL event: got %s data=%0h cycle %0d, want %s data=%0h cycle %0d",
                         kname(k), d, cyc, kname(e.kind), e.data, e.cyc_at);
            end
        end
    endtask

    // Monitor: sample 1 time unit after each rising edge.
    initial begin
        logic prev_err;
        prev_err = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                prev_err = 1'b0;
            end else begin
                if (timer_start) got(K_START, timer_delay);
                if (go_step_tck) got(K_GO, 8'h00);
                if (seq_done) got(K_DONE, 8'h00);
                if (timer_reset) got(K_RST, 8'h00);
                if (seq_err && !prev_err) got(K_ERR, 8'(seq_err_code));
                prev_err = seq_err;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        cmd_valid = 1'b0;
        abort = 1'b0;
        timer_done = 1'b0;
        step_button = 1'b0;
        step_mode_tck = 1'b0;
        tick();
        check_eq("reset_outputs", 32'({cmd_ready, timer_start, timer_delay, timer_reset, go_step_tck,
                                       seq_done, seq_err, seq_err_code, seq_state}), 32'd0);
        exp_q.delete();
        reset = 1'b0;
        tick();
        check_eq("ready_after_reset", 32'(cmd_ready), 32'd1);
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
        checks++;
        failures++;
        $display("FAIL ready_wait: cmd_ready stayed 0 for 50 cycles, want 1");
    endtask

    // One command against the timer model: timer answers lat cycles after start.
    task automatic run_cmd(input logic [7:0] d, input int lat, input bit do_abort, input bit press);
        bit         ok;
        int         n, m, p;
        logic [3:0] mult, ex;
        mult = d[7:4];
        ex   = d[3:0];
        wait_ready(ok);
        if (!ok) return;
        n = cyc;
        if (mult == 4'd0) begin
            expect_ev(K_DONE, 8'h00, n + 1);
        end else if (ex > 4'd7) begin
            expect_ev(K_ERR, 8'h01, n + 1);
        end else begin
            expect_ev(K_START, d, n + 1);
        end
        cmd_valid = 1'b1;
        cmd_delay = d;
        tick();
        cmd_valid = 1'b0;
        cmd_delay = 8'($urandom);
        if (mult == 4'd0) begin
            tick();
            check_eq("zero_mult_ready", 32'(cmd_ready), 32'd1);
            return;
        end
        if (ex > 4'd7) begin
            repeat (3) tick();
            check_eq("bad_exp_ready", 32'(cmd_ready), 32'd0);
            check_eq("bad_exp_code", 32'(seq_err_code), 32'd1);
            do_reset();
            return;
        end
        m = n + 1 + lat;
        if (lat < 3) press = 1'b0;
        p = press ? int'($urandom_range(m - 3, n + 1)) : -10;
        step_mode_tck = press;
        forever begin
            if (cyc == p) begin
                step_button = 1'b1;
                expect_ev(K_GO, 8'h00, p + int'(SYNC) + 1);
            end
            if (cyc == p + 2) step_button = 1'b0;
            if (cyc == n + 1 + lat / 2) check_eq("delay_held", 32'(timer_delay), 32'(d));
            if (cyc == m) begin
                timer_done = 1'b1;
                abort = do_abort;
                expect_ev(do_abort ? K_RST : K_DONE, 8'h00, m + 1);
                tick();
                timer_done = 1'b0;
                abort = 1'b0;
                break;
            end
            tick();
        end
        tick();
        check_eq("ready_back", 32'(cmd_ready), 32'd1);
        check_eq("idle_again", 32'(seq_state), 32'd0);
        step_mode_tck = 1'b0;
    endtask

    // Timer never answers; step mode held for h cycles of the wait.
    task automatic timeout_test(input int h);
        bit         ok;
        int         n, stop;
        logic [7:0] d;
        d = 8'h17;
        wait_ready(ok);
        if (!ok) return;
        n = cyc;
        step_mode_tck = (h > 0);
        expect_ev(K_START, d, n + 1);
`ifdef SCAN_DELAY_SEQ_WATCHDOG_EN
        expect_ev(K_RST, 8'h00, n + 2 + int'(WDOG) + h);
        expect_ev(K_ERR, 8'h02, n + 2 + int'(WDOG) + h);
        stop = n + 2 + int'(WDOG) + h + 3;
`else
        stop = n + 2 + int'(WDOG) + h + 50;
`endif
        cmd_valid = 1'b1;
        cmd_delay = d;
        tick();
        cmd_valid = 1'b0;
        while (cyc < stop) begin
            if (cyc == n + 2 + h) step_mode_tck = 1'b0;
            tick();
        end
`ifdef SCAN_DELAY_SEQ_WATCHDOG_EN
        check_eq("timeout_code", 32'(seq_err_code), 32'd2);
        check_eq("timeout_ready", 32'(cmd_ready), 32'd0);
        check_eq("timeout_state", 32'(seq_state), 32'd5);
        do_reset();
`else
        check_eq("no_timeout_err", 32'(seq_err), 32'd0);
        check_eq("still_waiting", 32'(seq_state), 32'd2);
        expect_ev(K_RST, 8'h00, cyc + 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        check_eq("abort_ready", 32'(cmd_ready), 32'd1);
`endif
    endtask

    initial begin
        bit ok;
        int c;
        do_reset();

        // Normal command, zero multiplier, bad exponent.
        run_cmd(8'h31, 30, 1'b0, 1'b0);
        run_cmd(8'h05, 0, 1'b0, 1'b0);
        run_cmd(8'h29, 0, 1'b0, 1'b0);

        // abort while idle has no effect.
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (3) tick();
        check_eq("abort_idle_ready", 32'(cmd_ready), 32'd1);

        // Step press in IDLE is lost; press during a long held wait is released.
        step_mode_tck = 1'b1;
        step_button = 1'b1;
        repeat (6) tick();
        step_button = 1'b0;
        repeat (4) tick();
        run_cmd(8'h73, 150, 1'b0, 1'b1);

        // abort together with timer_done: abort wins.
        run_cmd(8'h42, 20, 1'b1, 1'b0);

        // Watchdog, straight and with a step-mode hold.
        timeout_test(0);
        timeout_test(int'($urandom_range(40, 1)));

        // timer_done while idle is a protocol error.
        wait_ready(ok);
        c = cyc;
        expect_ev(K_ERR, 8'h03, c + 1);
        timer_done = 1'b1;
        tick();
        timer_done = 1'b0;
        repeat (3) tick();
        check_eq("done_idle_ready", 32'(cmd_ready), 32'd0);
        check_eq("done_idle_err", 32'(seq_err), 32'd1);
        do_reset();

        // Reset in the middle of a wait.
        wait_ready(ok);
        c = cyc;
        expect_ev(K_START, 8'h26, c + 1);
        cmd_valid = 1'b1;
        cmd_delay = 8'h26;
        tick();
        cmd_valid = 1'b0;
        repeat (10) tick();
        check_eq("mid_wait_state", 32'(seq_state), 32'd2);
        do_reset();

        // Randomized commands.
        for (int i = 0; i < 30; i++) begin
            run_cmd(8'($urandom), int'($urandom_range(60, 1)),
                    ($urandom_range(3, 0) == 0), ($urandom_range(1, 0) == 1));
        end

        repeat (5) tick();
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish, want finish");
        $fatal(1, "timeout");
    end

endmodule
